// File: rtl/pixel_color_resolve.sv
// Pixel colour resolve: collects per-ray float RGB samples for one pixel, then
// converts each sample to unorm8, box-averages them and presents an RGB888 pixel
// on a valid/ready port.
module pixel_color_resolve #(
  parameter int unsigned RPP_WIDTH = 6,
  parameter int unsigned PX_WIDTH  = 9,
  parameter int unsigned PY_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pixel_start,
  input  logic [PX_WIDTH-1:0]  x,
  input  logic [PY_WIDTH-1:0]  y,
  input  logic                 pixel_busy,
  input  logic                 ray_color_wr_en,
  input  logic [RPP_WIDTH-1:0] ray_color_update_ndx,
  input  logic [95:0]          ray_color,
  output logic                 busy,
  output logic                 pix_valid,
  input  logic                 pix_ready,
  output logic [PX_WIDTH-1:0]  pix_x,
  output logic [PY_WIDTH-1:0]  pix_y,
  output logic [23:0]          pix_rgb
);

  localparam int unsigned N     = 2 ** RPP_WIDTH;
  localparam int unsigned SUM_W = 8 + RPP_WIDTH;
  localparam int unsigned CNT_W = RPP_WIDTH + 1;
  localparam int unsigned HALF  = 2 ** (RPP_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_RESOLVE,
    S_EMIT
  } state_t;

  // IEEE-754 single to 8-bit unorm with saturation; negatives and tiny values flush to 0.
  function automatic logic [7:0] f32_to_unorm8(input logic [31:0] f);
    logic [7:0]  e;
    logic [23:0] mant;
    logic [15:0] f16;
    logic [24:0] prod;
    logic [7:0]  res;
    e    = f[30:23];
    mant = {1'b1, f[22:0]};
    f16  = 16'(mant >> 8) >> (8'd126 - e);
    prod = 25'(f16) * 25'd255 + 25'h0_8000;
    if (f[31] || (e == 8'd0))  res = 8'd0;
    else if (e >= 8'd127)      res = 8'hFF;
    else if (e <= 8'd110)      res = 8'd0;
    else                       res = 8'(prod >> 16);
    return res;
  endfunction

  // Round-to-nearest divide of a channel sum by the sample count.
  function automatic logic [7:0] avg_round(input logic [SUM_W-1:0] s);
    logic [SUM_W-1:0] t;
    t = s + SUM_W'(HALF);
    return 8'(t >> RPP_WIDTH);
  endfunction

  state_t             r_state;
  logic [N-1:0]       r_valid;
  logic               r_seen_busy;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_acc_en;
  logic               r_rd_vld;
  logic [95:0]        r_rd_data;
  logic [95:0]        r_mem [N];
  logic [SUM_W-1:0]   r_sum_r;
  logic [SUM_W-1:0]   r_sum_g;
  logic [SUM_W-1:0]   r_sum_b;

  logic                 w_wr_en;
  logic                 w_rd_en;
  logic [RPP_WIDTH-1:0] w_rd_addr;
  logic [7:0]           w_r8;
  logic [7:0]           w_g8;
  logic [7:0]           w_b8;

  assign w_wr_en   = (r_state == S_COLLECT) && ray_color_wr_en && !rst;
  assign w_rd_en   = (r_state == S_RESOLVE) && (r_cnt < CNT_W'(N));
  assign w_rd_addr = r_cnt[RPP_WIDTH-1:0];
  assign w_r8      = r_rd_vld ? f32_to_unorm8(r_rd_data[95:64]) : 8'd0;
  assign w_g8      = r_rd_vld ? f32_to_unorm8(r_rd_data[63:32]) : 8'd0;
  assign w_b8      = r_rd_vld ? f32_to_unorm8(r_rd_data[31:0])  : 8'd0;

  // Sample buffer: one write port from the ray pipe, one registered read port.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[ray_color_update_ndx] <= ray_color;
    if (w_rd_en) r_rd_data <= r_mem[w_rd_addr];
  end

  // Control FSM, valid bits, accumulators and registered pixel outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      busy        <= 1'b0;
      pix_valid   <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_rgb     <= '0;
      r_valid     <= '0;
      r_seen_busy <= 1'b0;
      r_cnt       <= '0;
      r_acc_en    <= 1'b0;
      r_rd_vld    <= 1'b0;
      r_sum_r     <= '0;
      r_sum_g     <= '0;
      r_sum_b     <= '0;
    end else begin
      r_acc_en <= w_rd_en;
      r_rd_vld <= r_valid[w_rd_addr];
      case (r_state)
        S_IDLE: begin
          if (pixel_start) begin
            pix_x       <= x;
            pix_y       <= y;
            r_valid     <= '0;
            r_seen_busy <= 1'b0;
            busy        <= 1'b1;
            r_state     <= S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (ray_color_wr_en) r_valid[ray_color_update_ndx] <= 1'b1;
          if (pixel_busy) r_seen_busy <= 1'b1;
          if (r_seen_busy && !pixel_busy) begin
            r_cnt   <= '0;
            r_sum_r <= '0;
            r_sum_g <= '0;
            r_sum_b <= '0;
            r_state <= S_RESOLVE;
          end
        end
        S_RESOLVE: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_acc_en) begin
            r_sum_r <= r_sum_r + SUM_W'(w_r8);
            r_sum_g <= r_sum_g + SUM_W'(w_g8);
            r_sum_b <= r_sum_b + SUM_W'(w_b8);
          end
          if (r_cnt == CNT_W'(N + 1)) begin
            pix_rgb   <= {avg_round(r_sum_r), avg_round(r_sum_g), avg_round(r_sum_b)};
            pix_valid <= 1'b1;
            r_state   <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (pix_ready) begin
            pix_valid <= 1'b0;
            busy      <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
